hypot_seq: RTL



---
 rtl/hypot_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hypot_seq.sv
// Iterative sqrt(x^2 + y^2) with valid/ready handshakes, one root bit per clock.
// Optional round-to-nearest output when HYPOT_ROUND_EN is defined.
module hypot_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic [WIDTH-1:0] sink_x,
    input  logic [WIDTH-1:0] sink_y,
    output logic             source_valid,
    input  logic             source_ready,
    output logic [WIDTH-1:0] source,
    output logic             source_exact
);

    // state  | meaning
    // IDLE   | waiting for operands, sink_ready high
    // SQUARE | forming x^2 + y^2, clearing root/remainder
    // ROOT   | one shift-subtract root step per cycle, MSB first
    // DONE   | result presented until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_SQUARE, S_ROOT, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_s2;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH:0]     r_rem;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_source;
    logic               r_exact;
    logic               r_src_valid;

    logic [2*WIDTH-1:0] w_x_ext;
    logic [2*WIDTH-1:0] w_y_ext;
    logic [2*WIDTH-1:0] w_s2;
    logic [WIDTH+2:0]   w_rem_sh;
    logic [WIDTH+2:0]   w_trial;
    logic [WIDTH+2:0]   w_rem_diff;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_result;

    // Squaring the sign-extended operands modulo 2^(2W) yields the true, non-negative square.
    assign w_x_ext    = {{WIDTH{r_x[WIDTH-1]}}, r_x};
    assign w_y_ext    = {{WIDTH{r_y[WIDTH-1]}}, r_y};
    assign w_s2       = (w_x_ext * w_x_ext) + (w_y_ext * w_y_ext);

    assign w_rem_sh   = {r_rem, r_s2[2*WIDTH-1 -: 2]};
    assign w_trial    = {1'b0, r_q, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_diff = w_rem_sh - w_trial;
    // Remainder never exceeds 2q, so WIDTH+1 bits always hold it.
    assign w_rem_next = w_ge ? w_rem_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

    always_comb begin
        w_result = w_q_next;
`ifdef HYPOT_ROUND_EN
        if (({1'b0, w_q_next} < w_rem_next) && !(&w_q_next))
            w_result = w_q_next + WIDTH'(1);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (sink_valid)   w_next = S_SQUARE;
            S_SQUARE:                   w_next = S_ROOT;
            S_ROOT:   if (r_cnt == '0)  w_next = S_DONE;
            S_DONE:   if (source_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_s2        <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_source    <= '0;
            r_exact     <= 1'b0;
            r_src_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sink_valid) begin
                        r_x <= sink_x;
                        r_y <= sink_y;
                    end
                end
                S_SQUARE: begin
                    r_s2  <= w_s2;
                    r_q   <= '0;
                    r_rem <= '0;
                    r_cnt <= CW'(WIDTH - 1);
                end
                S_ROOT: begin
                    r_s2  <= r_s2 << 2;
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_source    <= w_result;
                        r_exact     <= (w_rem_next == '0);
                        r_src_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (source_ready) r_src_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Gated by reset_n so the block never advertises readiness while held in reset.
    assign sink_ready   = reset_n && (r_state == S_IDLE);
    assign source_valid = r_src_valid;
    assign source       = r_source;
    assign source_exact = r_exact;

endmodule
